// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - radix-2 iterative MULT/DIV sequencer holding HI/LO for mfhi/mflo
// Define SIGNED_MD_EN for two's-complement operands; unsigned otherwise.
module muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [2*WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0]   opnd, opnd_n;
  logic [WIDTH-1:0]   hi_q, hi_n, lo_q, lo_n;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_trial, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next;
  logic [WIDTH-1:0]   mul_hi, mul_lo, div_rem, div_quo;
  logic               last;

  // MUL: acc = {partial, multiplier}; DIV: acc = {remainder, dividend/quotient}
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next  = {mul_sum, acc[WIDTH-1:1]};
  assign div_trial = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_trial - {1'b0, opnd};
  assign div_next  = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  assign last      = (cnt == CNT_W'(WIDTH-1));

`ifdef SIGNED_MD_EN
  logic               neg_q, nrem_q;
  logic [2*WIDTH-1:0] prod_s;

  assign a_mag            = srca[WIDTH-1] ? -srca : srca;
  assign b_mag            = srcb[WIDTH-1] ? -srcb : srcb;
  assign prod_s           = neg_q ? -mul_next : mul_next;
  assign {mul_hi, mul_lo} = prod_s;
  assign div_quo          = neg_q  ? -div_next[WIDTH-1:0]       : div_next[WIDTH-1:0];
  assign div_rem          = nrem_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_q  <= 1'b0;
      nrem_q <= 1'b0;
    end else if ((state == IDLE || state == FIN) && start && !flush) begin
      neg_q  <= srca[WIDTH-1] ^ srcb[WIDTH-1];
      nrem_q <= srca[WIDTH-1];
    end
  end
`else
  assign a_mag            = srca;
  assign b_mag            = srcb;
  assign {mul_hi, mul_lo} = mul_next;
  assign div_quo          = div_next[WIDTH-1:0];
  assign div_rem          = div_next[2*WIDTH-1:WIDTH];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      opnd  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      acc   <= acc_n;
      opnd  <= opnd_n;
      hi_q  <= hi_n;
      lo_q  <= lo_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    acc_n   = acc;
    opnd_n  = opnd;
    hi_n    = hi_q;
    lo_n    = lo_q;
    unique case (state)
      IDLE, FIN: begin
        state_n = IDLE;
        if (start && !flush) begin
          cnt_n = '0;
          if (!op) begin
            state_n = MUL;
            acc_n   = {{WIDTH{1'b0}}, b_mag};
            opnd_n  = a_mag;
          end else if (srcb != '0) begin
            state_n = DIV;
            acc_n   = {{WIDTH{1'b0}}, a_mag};
            opnd_n  = b_mag;
          end else begin
            // divide-by-zero skips the iterations entirely
            state_n = FIN;
            hi_n    = srca;
            lo_n    = '1;
          end
        end
      end
      MUL: begin
        if (flush) begin
          state_n = IDLE;
        end else begin
          acc_n = mul_next;
          cnt_n = cnt + CNT_W'(1);
          if (last) begin
            state_n = FIN;
            hi_n    = mul_hi;
            lo_n    = mul_lo;
          end
        end
      end
      DIV: begin
        if (flush) begin
          state_n = IDLE;
        end else begin
          acc_n = div_next;
          cnt_n = cnt + CNT_W'(1);
          if (last) begin
            state_n = FIN;
            hi_n    = div_rem;
            lo_n    = div_quo;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == MUL) || (state == DIV);
  assign done = (state == FIN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - scoreboard bench for muldiv_ctrl against an arithmetic reference model
module tb_muldiv_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, op, flush;
  logic [W-1:0] srca, srcb;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [W-1:0] eh;
    logic [W-1:0] el;
    int           ecyc;
  } exp_t;

  exp_t         sbq[$];
  exp_t         me;
  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] eh, output logic [W-1:0] el);
    logic [63:0] p;
`ifdef SIGNED_MD_EN
    longint sa, sb, q, r;
    sa = $signed(a);
    sb = $signed(b);
`endif
    if (o && b == '0) begin
      eh = a;
      el = '1;
    end else if (!o) begin
`ifdef SIGNED_MD_EN
      p = 64'(sa * sb);
`else
      p = {32'b0, a} * {32'b0, b};
`endif
      eh = p[63:32];
      el = p[31:0];
    end else begin
`ifdef SIGNED_MD_EN
      q  = sa / sb;
      r  = sa % sb;
      el = q[31:0];
      eh = r[31:0];
`else
      el = a / b;
      eh = a % b;
`endif
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        me = sbq.pop_front();
        check("hi", hi, me.eh);
        check("lo", lo, me.el);
        check("done_cycle", cyc, me.ecyc);
      end
    end
  end

  task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_done);
    exp_t         e;
    logic [W-1:0] h, l;
    model(o, a, b, h, l);
    start = 1'b1;
    op    = o;
    srca  = a;
    srcb  = b;
    if (expect_done) begin
      e.eh   = h;
      e.el   = l;
      e.ecyc = cyc + 1 + ((o && b == '0) ? 0 : W);
      sbq.push_back(e);
      last_hi = h;
      last_lo = l;
    end
    @(negedge clk);
    start = 1'b0;
    op    = 1'($urandom);
    srca  = $urandom;
    srcb  = $urandom;
  endtask

  task automatic wait_done(input int exp_busy, input string name);
    int bc   = 0;
    bit seen = 0;
    for (int i = 0; i < W + 8 && !seen; i++) begin
      if (done) seen = 1;
      else begin
        if (busy) bc++;
        @(negedge clk);
      end
    end
    check({name, "_done_seen"}, 64'(seen), 64'd1);
    if (exp_busy >= 0) check({name, "_busy_cycles"}, bc, exp_busy);
    check({name, "_busy_in_fin"}, 64'(busy), 64'd0);
  endtask

  logic [W-1:0] dir_a[6] = '{32'd7, 32'hFFFFFFFF, 32'd100, 32'd5, 32'hFFFFFFF9, 32'hFFFFFFF9};
  logic [W-1:0] dir_b[6] = '{32'd6, 32'hFFFFFFFF, 32'd7,   32'd0, 32'd3,        32'd2};
  logic         dir_o[6] = '{1'b0,  1'b0,         1'b1,    1'b1,  1'b0,         1'b1};

  initial begin
    logic         o;
    logic [W-1:0] a, b;
    reset = 1'b1; start = 1'b0; op = 1'b0; flush = 1'b0; srca = '0; srcb = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", hi, 64'd0);
    check("reset_lo", lo, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      issue(dir_o[i], dir_a[i], dir_b[i], 1);
      wait_done((dir_o[i] && dir_b[i] == '0) ? 0 : W, "directed");
      @(negedge clk);
    end

    // start while busy must not disturb the running op
    issue(1'b0, 32'd1234, 32'd5678, 1);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 1'b1; srca = 32'd99; srcb = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(-1, "ignored_start");
    @(negedge clk);

    issue(1'b0, 32'h12345678, 32'h9ABCDEF0, 1);
    wait_done(W, "b2b_first");
    issue(1'b1, 32'd1000, 32'd37, 1);
    wait_done(W, "b2b_second");
    @(negedge clk);

    // flush at iteration 10: no done, HI/LO untouched
    issue(1'b0, 32'd3, 32'd4, 0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_hi", hi, last_hi);
    check("flush_lo", lo, last_lo);
    repeat (W + 4) @(negedge clk);
    check("flush_hi_hold", hi, last_hi);
    check("flush_lo_hold", lo, last_lo);

    // asynchronous reset in the middle of a divide
    issue(1'b1, 32'd1000, 32'd3, 1);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_busy", 64'(busy), 64'd0);
    check("async_reset_done", 64'(done), 64'd0);
    check("async_reset_hi", hi, 64'd0);
    check("async_reset_lo", lo, 64'd0);
    void'(sbq.pop_back());
    last_hi = '0;
    last_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 24; i++) begin
      o = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 500));
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 40));
        default: b = $urandom;
      endcase
      issue(o, a, b, 1);
      wait_done((o && b == '0) ? 0 : W, "random");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
